// File: rtl/region_probe.sv
// region_probe: sweeps a square framebuffer region column-major, one read per cycle,
// and reports the first pixel whose colour differs from the latched background.
package region_probe_pkg;
    localparam logic [2:0] BG_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

module region_probe
    import region_probe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [6:0] size,
    input  logic [2:0] bg_colour,
    output logic       rd_en,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    input  logic [2:0] rd_colour,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [7:0] hit_x,
    output logic [6:0] hit_y,
    output logic [2:0] hit_colour
);

    state_t     state;
    state_t     next_state;

    logic [7:0] x_lat;
    logic [6:0] y_lat;
    logic [6:0] size_lat;
    logic [2:0] bg_lat;
    logic [6:0] qx;
    logic [6:0] qy;
    logic [6:0] qx_next;
    logic [6:0] qy_next;

    logic       pipe_valid;
    logic [7:0] pipe_x;
    logic [6:0] pipe_y;

    logic       go_ok;
    logic       col_end;
    logic       last_read;
    logic       hit_now;

    assign go_ok     = (state == IDLE) && go;
    assign col_end   = (qy == size_lat - 7'd1);
    assign last_read = col_end && (qx == size_lat - 7'd1);
    assign qy_next   = col_end ? 7'd0 : qy + 7'd1;
    assign qx_next   = col_end ? qx + 7'd1 : qx;

    // The in-flight read issued during the hit compare lands in DONE and is ignored there.
    assign hit_now = pipe_valid && ((state == SCAN) || (state == DRAIN))
                     && (rd_colour != bg_lat);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (go) begin
                    next_state = (size == 7'd0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (hit_now) begin
                    next_state = DONE;
                end else if (last_read) begin
                    next_state = DRAIN;
                end
            end
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en      <= 1'b0;
            rd_x       <= 8'd0;
            rd_y       <= 7'd0;
            x_lat      <= 8'd0;
            y_lat      <= 7'd0;
            size_lat   <= 7'd0;
            bg_lat     <= BG_DEFAULT;
            qx         <= 7'd0;
            qy         <= 7'd0;
            pipe_valid <= 1'b0;
            pipe_x     <= 8'd0;
            pipe_y     <= 7'd0;
            hit        <= 1'b0;
            hit_x      <= 8'd0;
            hit_y      <= 7'd0;
            hit_colour <= 3'd0;
        end else begin
            rd_en      <= (next_state == SCAN);
            pipe_valid <= rd_en;
            pipe_x     <= rd_x;
            pipe_y     <= rd_y;

            if (go_ok) begin
                x_lat      <= x_in;
                y_lat      <= y_in;
                size_lat   <= size;
                bg_lat     <= bg_colour;
                qx         <= 7'd0;
                qy         <= 7'd0;
                rd_x       <= x_in;
                rd_y       <= y_in;
                hit        <= 1'b0;
                hit_x      <= 8'd0;
                hit_y      <= 7'd0;
                hit_colour <= 3'd0;
            end else if (state == SCAN) begin
                qx   <= qx_next;
                qy   <= qy_next;
                rd_x <= x_lat + {1'b0, qx_next};
                rd_y <= y_lat + qy_next;
            end

            if (hit_now) begin
                hit        <= 1'b1;
                hit_x      <= pipe_x;
                hit_y      <= pipe_y;
                hit_colour <= rd_colour;
            end
        end
    end

endmodule
